packed_word_fifo: RTL and testbench

Buffers the 32-bit words produced by the upstream byte-to-word shift/pack stage. Each word is captured when wr_valid is asserted. The buffer is a circular FIFO with wr_valid/wr_ready write handshake and rd_valid/rd_ready read handshake. It decouples the packer from the downstream word consumer and flags any word the packer presents while the buffer is full.

---
 rtl/packed_word_fifo_if.sv | 25 ++
 rtl/packed_word_fifo.sv | 69 ++++++
 tb/tb_packed_word_fifo.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/packed_word_fifo_if.sv
// Write/read handshake bundle between the word packer, the FIFO and the word consumer.
interface packed_word_fifo_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 3
);
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_data, wr_valid, rd_ready,
        input  wr_ready, rd_data, rd_valid, count, overflow, underflow
    );

    modport slave (
        input  wr_data, wr_valid, rd_ready,
        output wr_ready, rd_data, rd_valid, count, overflow, underflow
    );
endinterface

// File: rtl/packed_word_fifo.sv
// Circular first-word-fall-through FIFO for packed 32-bit words, with sticky
// overflow/underflow flags for handshake violations.
module packed_word_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    packed_word_fifo_if.slave bus
);
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              full_c, empty_c, wr_en_c, rd_en_c;

    // Handshake decode and next-state; a full buffer refuses writes even when a read frees a slot.
    always_comb begin
        full_c      = (count_q == CNT_W'(DEPTH));
        empty_c     = (count_q == '0);
        wr_en_c     = bus.wr_valid && !full_c;
        rd_en_c     = bus.rd_ready && !empty_c;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q  | (bus.wr_valid && full_c);
        underflow_d = underflow_q | (bus.rd_ready && empty_c);
        if (wr_en_c) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (rd_en_c) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        case ({wr_en_c, rd_en_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is never cleared; reset only blocks the write.
    always_ff @(posedge clk) begin
        if (!rst && wr_en_c) mem_q[wr_ptr_q] <= bus.wr_data;
    end

    assign bus.wr_ready  = !full_c;
    assign bus.rd_valid  = !empty_c;
    assign bus.rd_data   = empty_c ? '0 : mem_q[rd_ptr_q];
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_packed_word_fifo.sv
// Self-checking bench for packed_word_fifo against a queue-based reference model.
module tb_packed_word_fifo;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned ADDR_W = 3;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [DATA_W-1:0] q[$];
    bit                m_ovf;
    bit                m_unf;

    packed_word_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    packed_word_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance the model by one edge from the currently driven inputs, then step the DUT.
    task automatic cycle();
        bit wr_acc;
        bit rd_acc;
        if (rst) begin
            q.delete();
            m_ovf = 0;
            m_unf = 0;
        end else begin
            wr_acc = bus.wr_valid && (q.size() < DEPTH);
            rd_acc = bus.rd_ready && (q.size() > 0);
            if (bus.wr_valid && !wr_acc) m_ovf = 1;
            if (bus.rd_ready && q.size() == 0) m_unf = 1;
            if (rd_acc) void'(q.pop_front());
            if (wr_acc) q.push_back(bus.wr_data);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.rd_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 6;
        if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.count); end
        if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b exp 0", bus.rd_valid); end
        if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %b exp 1", bus.wr_ready); end
        if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", bus.overflow); end
        if (bus.underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow got %b exp 0", bus.underflow); end
        if (bus.rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data got %h exp 0", bus.rd_data); end
    endtask

    task automatic test_basic_write();
        logic [DATA_W-1:0] words [3];
        words[0] = 32'h11223344;
        words[1] = 32'h55667788;
        words[2] = 32'h99AABBCC;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = words[i];
            cycle();
            if (i == 0) begin
                checks += 2;
                if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL latency_rd_valid got %b exp 1", bus.rd_valid); end
                if (bus.rd_data !== 32'h11223344) begin errors++; $display("FAIL latency_rd_data got %h exp 11223344", bus.rd_data); end
            end
        end
        idle_inputs();
        checks += 3;
        if (bus.count !== 4'd3) begin errors++; $display("FAIL basic_count got %0d exp 3", bus.count); end
        if (bus.overflow !== 1'b0) begin errors++; $display("FAIL basic_overflow got %b exp 0", bus.overflow); end
        if (bus.rd_data !== 32'h11223344) begin errors++; $display("FAIL basic_head got %h exp 11223344", bus.rd_data); end
    endtask

    task automatic test_fill_overflow();
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = DATA_W'(i);
            cycle();
        end
        checks += 2;
        if (bus.count !== 4'd8) begin errors++; $display("FAIL fill_count got %0d exp 8", bus.count); end
        if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL fill_wr_ready got %b exp 0", bus.wr_ready); end
        bus.wr_data = 32'hDEADBEEF;
        cycle();
        idle_inputs();
        checks += 2;
        if (bus.overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow got %b exp 1", bus.overflow); end
        if (bus.count !== 4'd8) begin errors++; $display("FAIL fill_count_after_drop got %0d exp 8", bus.count); end
        bus.rd_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            checks += 2;
            if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL drain_rd_valid[%0d] got %b exp 1", i, bus.rd_valid); end
            if (bus.rd_data !== DATA_W'(i)) begin errors++; $display("FAIL drain_data[%0d] got %h exp %h", i, bus.rd_data, DATA_W'(i)); end
            cycle();
        end
        bus.rd_ready = 1'b0;
        checks += 2;
        if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b exp 0", bus.rd_valid); end
        if (bus.underflow !== 1'b0) begin errors++; $display("FAIL drain_underflow got %b exp 0", bus.underflow); end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] exp_head;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 32'h1000 + DATA_W'(i);
            cycle();
        end
        bus.rd_ready = 1'b1;
        for (int i = 4; i < 24; i++) begin
            exp_head = 32'h1000 + DATA_W'(i - 4);
            bus.wr_data = 32'h1000 + DATA_W'(i);
            checks += 1;
            if (bus.rd_data !== exp_head) begin errors++; $display("FAIL b2b_order[%0d] got %h exp %h", i, bus.rd_data, exp_head); end
            cycle();
            checks += 1;
            if (bus.count !== 4'd4) begin errors++; $display("FAIL b2b_count[%0d] got %0d exp 4", i, bus.count); end
        end
        idle_inputs();
        checks += 1;
        if (bus.rd_data !== 32'h1000 + 32'd20) begin errors++; $display("FAIL b2b_final_head got %h exp %h", bus.rd_data, 32'h1014); end
    endtask

    task automatic test_full_read();
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 32'h2000 + DATA_W'(i);
            cycle();
        end
        bus.wr_data  = 32'hCAFEF00D;
        bus.rd_ready = 1'b1;
        cycle();
        idle_inputs();
        checks += 4;
        if (bus.count !== 4'd7) begin errors++; $display("FAIL full_read_count got %0d exp 7", bus.count); end
        if (bus.overflow !== 1'b1) begin errors++; $display("FAIL full_read_overflow got %b exp 1", bus.overflow); end
        if (bus.rd_data !== 32'h2002) begin errors++; $display("FAIL full_read_head got %h exp 2002", bus.rd_data); end
        if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL full_read_wr_ready got %b exp 1", bus.wr_ready); end
    endtask

    task automatic test_empty_write();
        do_reset();
        bus.wr_valid = 1'b1;
        bus.wr_data  = 32'hA5A5A5A5;
        bus.rd_ready = 1'b1;
        cycle();
        idle_inputs();
        checks += 3;
        if (bus.underflow !== 1'b1) begin errors++; $display("FAIL empty_wr_underflow got %b exp 1", bus.underflow); end
        if (bus.count !== 4'd1) begin errors++; $display("FAIL empty_wr_count got %0d exp 1", bus.count); end
        if (bus.rd_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL empty_wr_data got %h exp a5a5a5a5", bus.rd_data); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 32'h3000 + DATA_W'(i);
            cycle();
        end
        bus.wr_valid = 1'b0;
        bus.rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        bus.rd_ready = 1'b0;
        checks += 2;
        if (bus.count !== 4'd5) begin errors++; $display("FAIL mid_pre_count got %0d exp 5", bus.count); end
        if (bus.overflow !== 1'b1) begin errors++; $display("FAIL mid_pre_overflow got %b exp 1", bus.overflow); end
        rst = 1'b1;
        bus.wr_valid = 1'b1;
        bus.wr_data  = 32'h77777777;
        cycle();
        rst = 1'b0;
        idle_inputs();
        checks += 5;
        if (bus.count !== 4'd0) begin errors++; $display("FAIL mid_count got %0d exp 0", bus.count); end
        if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL mid_rd_valid got %b exp 0", bus.rd_valid); end
        if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL mid_wr_ready got %b exp 1", bus.wr_ready); end
        if (bus.overflow !== 1'b0) begin errors++; $display("FAIL mid_overflow got %b exp 0", bus.overflow); end
        if (bus.underflow !== 1'b0) begin errors++; $display("FAIL mid_underflow got %b exp 0", bus.underflow); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            rst          = ($urandom_range(0, 59) == 0);
            bus.wr_valid = ($urandom_range(0, 99) < 55);
            bus.rd_ready = ($urandom_range(0, 99) < 45);
            bus.wr_data  = $urandom();
            cycle();
            rst = 1'b0;
            checks += 5;
            if (bus.count !== 4'(q.size())) begin errors++; $display("FAIL rand_count[%0d] got %0d exp %0d", n, bus.count, q.size()); end
            if (bus.rd_valid !== (q.size() != 0)) begin errors++; $display("FAIL rand_rd_valid[%0d] got %b exp %b", n, bus.rd_valid, q.size() != 0); end
            if (bus.wr_ready !== (q.size() != DEPTH)) begin errors++; $display("FAIL rand_wr_ready[%0d] got %b exp %b", n, bus.wr_ready, q.size() != DEPTH); end
            if (bus.overflow !== m_ovf) begin errors++; $display("FAIL rand_overflow[%0d] got %b exp %b", n, bus.overflow, m_ovf); end
            if (bus.underflow !== m_unf) begin errors++; $display("FAIL rand_underflow[%0d] got %b exp %b", n, bus.underflow, m_unf); end
            if (q.size() != 0) begin
                checks += 1;
                if (bus.rd_data !== q[0]) begin errors++; $display("FAIL rand_rd_data[%0d] got %h exp %h", n, bus.rd_data, q[0]); end
            end
        end
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_ovf  = 0;
        m_unf  = 0;
        rst    = 1'b1;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_basic_write();
        test_fill_overflow();
        test_back_to_back();
        test_full_read();
        test_empty_write();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
